// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset control unit: a five-state FSM that decodes the
// latched instruction into datapath selects and counts retired instructions.
module multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instr,
    input  logic             IsEq,
    input  logic             DMReady,
    output logic             IRWe,
    output logic             PCWe,
    output logic             DMReq,
    output logic             WeGRF,
    output logic             WeDM,
    output logic [1:0]       RegDst,
    output logic [1:0]       WhichToReg,
    output logic             ALUSrc,
    output logic             IsSignExt,
    output logic             IsBranchType,
    output logic             IsJType,
    output logic             IsJr,
    output logic [3:0]       ALUOp,
    output logic [2:0]       State,
    output logic [CNT_W-1:0] InstrCnt
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        C_ADDU, C_SUBU, C_JR, C_ORI, C_LUI, C_LW, C_SW, C_BEQ, C_J, C_JAL, C_ILLEGAL
    } iclass_t;

    state_t     state;
    state_t     next_state;
    iclass_t    iclass;
    logic [3:0] alu_op;
    logic       alu_src;
    logic       sign_ext;
    logic [CNT_W-1:0] instr_cnt;

    // Branch resolution happens in the datapath, so the equality flag and
    // the register/immediate fields are not consumed here.
    logic unused;
    assign unused = ^{IsEq, instr[25:6]};

    always_comb begin
        iclass = C_ILLEGAL;
        case (instr[31:26])
            6'h00: begin
                case (instr[5:0])
                    6'h21:   iclass = C_ADDU;
                    6'h23:   iclass = C_SUBU;
                    6'h08:   iclass = C_JR;
                    default: iclass = C_ILLEGAL;
                endcase
            end
            6'h0D:   iclass = C_ORI;
            6'h0F:   iclass = C_LUI;
            6'h23:   iclass = C_LW;
            6'h2B:   iclass = C_SW;
            6'h04:   iclass = C_BEQ;
            6'h02:   iclass = C_J;
            6'h03:   iclass = C_JAL;
            default: iclass = C_ILLEGAL;
        endcase
    end

    // ALU selects depend only on the class; EXEC, MEM and WB all reuse them.
    always_comb begin
        alu_op   = 4'd0;
        alu_src  = 1'b0;
        sign_ext = 1'b0;
        case (iclass)
            C_SUBU: alu_op = 4'd1;
            C_ORI: begin
                alu_op  = 4'd2;
                alu_src = 1'b1;
            end
            C_LUI: begin
                alu_op  = 4'd3;
                alu_src = 1'b1;
            end
            C_LW, C_SW: begin
                alu_src  = 1'b1;
                sign_ext = 1'b1;
            end
            C_BEQ:   alu_op = 4'd1;
            default: alu_op = 4'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= FETCH;
        else        state <= next_state;
    end

    always_comb begin
        next_state = FETCH;
        case (state)
            FETCH: next_state = DECODE;
            DECODE: begin
                case (iclass)
                    C_J, C_JR, C_ILLEGAL: next_state = FETCH;
                    C_JAL:                next_state = WB;
                    default:              next_state = EXEC;
                endcase
            end
            EXEC: begin
                case (iclass)
                    C_ADDU, C_SUBU, C_ORI, C_LUI: next_state = WB;
                    C_LW, C_SW:                   next_state = MEM;
                    default:                      next_state = FETCH;
                endcase
            end
            MEM: begin
                if (!DMReady && (iclass == C_LW || iclass == C_SW)) next_state = MEM;
                else if (iclass == C_LW)                            next_state = WB;
                else                                                next_state = FETCH;
            end
            WB:      next_state = FETCH;
            default: next_state = FETCH;
        endcase
    end

    // Reset gates every control output so nothing fires while held in FETCH.
    always_comb begin
        IRWe         = 1'b0;
        PCWe         = 1'b0;
        DMReq        = 1'b0;
        WeGRF        = 1'b0;
        WeDM         = 1'b0;
        RegDst       = 2'd0;
        WhichToReg   = 2'd0;
        ALUSrc       = 1'b0;
        IsSignExt    = 1'b0;
        IsBranchType = 1'b0;
        IsJType      = 1'b0;
        IsJr         = 1'b0;
        ALUOp        = 4'd0;
        if (reset) begin
            case (state)
                FETCH: IRWe = 1'b1;
                DECODE: begin
                    case (iclass)
                        C_J: begin
                            PCWe    = 1'b1;
                            IsJType = 1'b1;
                        end
                        C_JR: begin
                            PCWe = 1'b1;
                            IsJr = 1'b1;
                        end
                        C_ILLEGAL: PCWe = 1'b1;
                        default:   PCWe = 1'b0;
                    endcase
                end
                EXEC: begin
                    ALUOp     = alu_op;
                    ALUSrc    = alu_src;
                    IsSignExt = sign_ext;
                    if (iclass == C_BEQ) begin
                        PCWe         = 1'b1;
                        IsBranchType = 1'b1;
                    end
                end
                MEM: begin
                    DMReq     = 1'b1;
                    ALUOp     = alu_op;
                    ALUSrc    = alu_src;
                    IsSignExt = sign_ext;
                    WeDM      = (iclass == C_SW) && DMReady;
                    PCWe      = (iclass == C_SW) && DMReady;
                end
                WB: begin
                    WeGRF     = 1'b1;
                    PCWe      = 1'b1;
                    ALUOp     = alu_op;
                    ALUSrc    = alu_src;
                    IsSignExt = sign_ext;
                    case (iclass)
                        C_LW: begin
                            RegDst     = 2'd1;
                            WhichToReg = 2'd1;
                        end
                        C_ORI, C_LUI: RegDst = 2'd1;
                        C_JAL: begin
                            RegDst     = 2'd2;
                            WhichToReg = 2'd2;
                            IsJType    = 1'b1;
                        end
                        default: RegDst = 2'd0;
                    endcase
                end
                default: IRWe = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)    instr_cnt <= '0;
        else if (PCWe) instr_cnt <= instr_cnt + CNT_W'(1);
    end

    assign State    = state;
    assign InstrCnt = instr_cnt;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class through
// its state sequence and checks outputs mid-cycle against hand-worked values.
module tb_multicycle_ctrl;

    logic        clk;
    logic        reset;
    logic [31:0] instr;
    logic        IsEq;
    logic        DMReady;
    logic        IRWe, PCWe, DMReq, WeGRF, WeDM;
    logic [1:0]  RegDst, WhichToReg;
    logic        ALUSrc, IsSignExt, IsBranchType, IsJType, IsJr;
    logic [3:0]  ALUOp;
    logic [2:0]  State;
    logic [31:0] InstrCnt;

    int checks = 0;
    int errors = 0;

    multicycle_ctrl #(.CNT_W(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .instr        (instr),
        .IsEq         (IsEq),
        .DMReady      (DMReady),
        .IRWe         (IRWe),
        .PCWe         (PCWe),
        .DMReq        (DMReq),
        .WeGRF        (WeGRF),
        .WeDM         (WeDM),
        .RegDst       (RegDst),
        .WhichToReg   (WhichToReg),
        .ALUSrc       (ALUSrc),
        .IsSignExt    (IsSignExt),
        .IsBranchType (IsBranchType),
        .IsJType      (IsJType),
        .IsJr         (IsJr),
        .ALUOp        (ALUOp),
        .State        (State),
        .InstrCnt     (InstrCnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic applyStimulus(input logic [31:0] i, input logic eq, input logic rdy);
        instr   = i;
        IsEq    = eq;
        DMReady = rdy;
    endtask

    // Advance one clock and settle a little past the rising edge.
    task automatic nextCycle();
        @(posedge clk);
        #2;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        reset = 1'b0;
        applyStimulus(32'h0, 1'b0, 1'b1);
        #2;
        checkOutput("rst_state", State, 0);
        checkOutput("rst_irwe", IRWe, 0);
        checkOutput("rst_cnt", InstrCnt, 0);
        nextCycle();
        nextCycle();
        checkOutput("rst_hold_state", State, 0);
        checkOutput("rst_hold_pcwe", PCWe, 0);
        reset = 1'b1;
        #1;
        checkOutput("fetch_irwe", IRWe, 1);

        $display("[TB] addu");
        applyStimulus(32'h00221821, 1'b0, 1'b1);
        checkOutput("addu_s0", State, 0);
        nextCycle();
        checkOutput("addu_s1", State, 1);
        checkOutput("addu_dec_pcwe", PCWe, 0);
        checkOutput("addu_dec_irwe", IRWe, 0);
        nextCycle();
        checkOutput("addu_s2", State, 2);
        checkOutput("addu_aluop", ALUOp, 0);
        checkOutput("addu_alusrc", ALUSrc, 0);
        checkOutput("addu_exec_wegrf", WeGRF, 0);
        nextCycle();
        checkOutput("addu_s4", State, 4);
        checkOutput("addu_wegrf", WeGRF, 1);
        checkOutput("addu_regdst", RegDst, 0);
        checkOutput("addu_w2r", WhichToReg, 0);
        checkOutput("addu_pcwe", PCWe, 1);
        checkOutput("addu_cnt0", InstrCnt, 0);
        nextCycle();
        checkOutput("addu_back", State, 0);
        checkOutput("addu_cnt1", InstrCnt, 1);

        $display("[TB] lw with stalls");
        applyStimulus(32'h8C220004, 1'b0, 1'b0);
        nextCycle();
        checkOutput("lw_s1", State, 1);
        nextCycle();
        checkOutput("lw_s2", State, 2);
        checkOutput("lw_alusrc", ALUSrc, 1);
        checkOutput("lw_sext", IsSignExt, 1);
        checkOutput("lw_exec_dmreq", DMReq, 0);
        for (int k = 1; k <= 3; k++) begin
            nextCycle();
            checkOutput($sformatf("lw_mem%0d_state", k), State, 3);
            checkOutput($sformatf("lw_mem%0d_dmreq", k), DMReq, 1);
            checkOutput($sformatf("lw_mem%0d_pcwe", k), PCWe, 0);
        end
        nextCycle();
        DMReady = 1'b1;
        #1;
        checkOutput("lw_mem4_state", State, 3);
        checkOutput("lw_mem4_wedm", WeDM, 0);
        checkOutput("lw_mem4_pcwe", PCWe, 0);
        checkOutput("lw_mem4_alusrc", ALUSrc, 1);
        nextCycle();
        checkOutput("lw_s4", State, 4);
        checkOutput("lw_regdst", RegDst, 1);
        checkOutput("lw_w2r", WhichToReg, 1);
        checkOutput("lw_wegrf", WeGRF, 1);
        nextCycle();
        checkOutput("lw_back", State, 0);
        checkOutput("lw_cnt", InstrCnt, 2);

        $display("[TB] beq");
        applyStimulus(32'h10220003, 1'b1, 1'b1);
        nextCycle();
        nextCycle();
        checkOutput("beq_s2", State, 2);
        checkOutput("beq_br", IsBranchType, 1);
        checkOutput("beq_pcwe", PCWe, 1);
        checkOutput("beq_aluop", ALUOp, 1);
        checkOutput("beq_alusrc", ALUSrc, 0);
        nextCycle();
        checkOutput("beq_back", State, 0);
        checkOutput("beq_cnt", InstrCnt, 3);

        $display("[TB] jal");
        applyStimulus(32'h0C000010, 1'b0, 1'b1);
        nextCycle();
        checkOutput("jal_s1", State, 1);
        checkOutput("jal_dec_pcwe", PCWe, 0);
        nextCycle();
        checkOutput("jal_s4", State, 4);
        checkOutput("jal_regdst", RegDst, 2);
        checkOutput("jal_w2r", WhichToReg, 2);
        checkOutput("jal_wegrf", WeGRF, 1);
        checkOutput("jal_jtype", IsJType, 1);
        checkOutput("jal_pcwe", PCWe, 1);
        nextCycle();
        checkOutput("jal_back", State, 0);
        checkOutput("jal_cnt", InstrCnt, 4);

        $display("[TB] illegal");
        applyStimulus(32'hFC000000, 1'b0, 1'b1);
        checkOutput("ill_f_wegrf", WeGRF, 0);
        nextCycle();
        checkOutput("ill_s1", State, 1);
        checkOutput("ill_pcwe", PCWe, 1);
        checkOutput("ill_wegrf", WeGRF, 0);
        checkOutput("ill_wedm", WeDM, 0);
        nextCycle();
        checkOutput("ill_back", State, 0);
        checkOutput("ill_cnt", InstrCnt, 5);

        $display("[TB] jr");
        applyStimulus(32'h03E00008, 1'b0, 1'b1);
        nextCycle();
        checkOutput("jr_isjr", IsJr, 1);
        checkOutput("jr_pcwe", PCWe, 1);
        checkOutput("jr_jtype", IsJType, 0);
        nextCycle();
        checkOutput("jr_back", State, 0);

        $display("[TB] ori");
        applyStimulus(32'h34220005, 1'b0, 1'b1);
        nextCycle();
        nextCycle();
        checkOutput("ori_aluop", ALUOp, 2);
        checkOutput("ori_alusrc", ALUSrc, 1);
        checkOutput("ori_sext", IsSignExt, 0);
        nextCycle();
        checkOutput("ori_s4", State, 4);
        checkOutput("ori_regdst", RegDst, 1);
        checkOutput("ori_wb_aluop", ALUOp, 2);
        nextCycle();
        checkOutput("ori_cnt", InstrCnt, 7);

        $display("[TB] sw with reset mid-MEM");
        applyStimulus(32'hAC220004, 1'b0, 1'b0);
        nextCycle();
        nextCycle();
        nextCycle();
        checkOutput("sw_s3", State, 3);
        checkOutput("sw_dmreq", DMReq, 1);
        checkOutput("sw_wedm_wait", WeDM, 0);
        checkOutput("sw_pcwe_wait", PCWe, 0);
        DMReady = 1'b1;
        #1;
        checkOutput("sw_wedm_rdy", WeDM, 1);
        DMReady = 1'b0;
        #1;
        reset = 1'b0;
        #1;
        checkOutput("swrst_state", State, 0);
        checkOutput("swrst_cnt", InstrCnt, 0);
        checkOutput("swrst_wedm", WeDM, 0);
        checkOutput("swrst_dmreq", DMReq, 0);
        checkOutput("swrst_pcwe", PCWe, 0);

        nextCycle();
        DMReady = 1'b1;
        reset   = 1'b1;
        #1;
        checkOutput("post_fetch", State, 0);
        nextCycle();
        nextCycle();
        nextCycle();
        checkOutput("sw2_s3", State, 3);
        checkOutput("sw2_wedm", WeDM, 1);
        checkOutput("sw2_pcwe", PCWe, 1);
        checkOutput("sw2_wegrf", WeGRF, 0);
        nextCycle();
        checkOutput("sw2_back", State, 0);
        checkOutput("sw2_cnt", InstrCnt, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter CNT_W, default 32, width of the retired-instruction counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 instr  input  32  current instruction from the datapath instruction register; stable from the cycle after FETCH until the next FETCH.
REQ-005 IsEq  input  1  ALU equality flag from the datapath.
REQ-006 DMReady  input  1  data-memory completion handshake.
REQ-007 IRWe  output  1  latch the fetched instruction into the instruction register.
REQ-008 PCWe  output  1  update PC from NPC this edge.
REQ-009 DMReq  output  1  data-memory access request.
REQ-010 WeGRF, WeDM  output  1 each  register-file and data-memory write enables.
REQ-011 RegDst  output  2  write-address select: 0=rd, 1=rt, 2=$31.
REQ-012 WhichToReg  output  2  write-data select: 0=ALU, 1=DM, 2=PC+4.
REQ-013 ALUSrc, IsSignExt, IsBranchType, IsJType, IsJr  output  1 each  datapath selects.
REQ-014 ALUOp  output  4  0=add, 1=sub, 2=or, 3=lui (imm<<16); other codes unused.
REQ-015 State  output  3  current FSM state (debug).
REQ-016 InstrCnt  output  CNT_W  retired-instruction count.

Function
REQ-017 FSM states: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; codes 5-7 SHALL go to FETCH on the next edge with all outputs 0.
REQ-018 Decode classes (op=instr[31:26], funct=instr[5:0]): addu (op 0, funct 0x21), subu (op 0, funct 0x23), jr (op 0, funct 0x08), ori 0x0D, lui 0x0F, lw 0x23, sw 0x2B, beq 0x04, j 0x02, jal 0x03; anything else is ILLEGAL.
REQ-019 FETCH: IRWe=1, all other write/request outputs 0; next state DECODE unconditionally.
REQ-020 DECODE: j, jr, ILLEGAL -> FETCH with PCWe=1 (jr: IsJr=1; j: IsJType=1); jal -> WB; all others -> EXEC.
REQ-021 EXEC: addu/subu/ori/lui -> WB; lw/sw -> MEM; beq -> FETCH with PCWe=1, IsBranchType=1, ALUOp=1, ALUSrc=0.
REQ-022 EXEC selects: addu ALUOp=0/ALUSrc=0; subu ALUOp=1/ALUSrc=0; ori ALUOp=2/ALUSrc=1/IsSignExt=0; lui ALUOp=3/ALUSrc=1; lw/sw ALUOp=0/ALUSrc=1/IsSignExt=1.
REQ-023 MEM: DMReq=1 and ALU selects held as in EXEC; sw drives WeDM=1 only in the cycle DMReady=1; state held while DMReady=0; on DMReady=1, lw -> WB, sw -> FETCH with PCWe=1.
REQ-024 WB: WeGRF=1, PCWe=1, next FETCH; R-type RegDst=0/WhichToReg=0; ori/lui RegDst=1/WhichToReg=0; lw RegDst=1/WhichToReg=1; jal RegDst=2/WhichToReg=2/IsJType=1; ALU selects held as in EXEC.
REQ-025 PCWe SHALL assert exactly once per instruction, in its final cycle; WeGRF and WeDM SHALL each assert at most once per instruction.
REQ-026 Latency with DMReady tied high: j/jr/ILLEGAL 2 cycles, jal/beq 3, R-type/ori/lui/sw 4, lw 5; each DMReady=0 cycle in MEM adds 1.
REQ-027 Outputs are combinational from State and instr; any output not listed for a state SHALL be 0.
REQ-028 InstrCnt SHALL increment by 1 on every edge where PCWe=1, wrapping from all-ones to 0.

Reset
REQ-029 reset=0 SHALL force State=FETCH and InstrCnt=0 immediately, without waiting for a clock edge, including mid-MEM.
REQ-030 While reset=0, all outputs except State and InstrCnt SHALL be 0, including IRWe.
REQ-031 The first rising edge after reset returns to 1 SHALL be a FETCH cycle.

Verification
REQ-032 addu 0x00221821 -> states 0,1,2,4; WB has WeGRF=1, RegDst=0, WhichToReg=0, PCWe=1; InstrCnt 0->1.
REQ-033 lw 0x8C220004 with DMReady low 3 cycles -> MEM held 4 cycles with DMReq=1, then WB with RegDst=1, WhichToReg=1; 8 cycles total.
REQ-034 beq 0x10220003 with IsEq=1 -> EXEC has IsBranchType=1, PCWe=1, ALUOp=1; next state FETCH after 3 cycles.
REQ-035 jal 0x0C000010 -> DECODE->WB; WB has RegDst=2, WhichToReg=2, WeGRF=1, IsJType=1, PCWe=1.
REQ-036 ILLEGAL 0xFC000000 -> 2 cycles; WeGRF=WeDM=0 throughout; InstrCnt +1.
REQ-037 reset=0 asserted mid-MEM of sw -> State=0, InstrCnt=0, WeDM/DMReq/PCWe=0 before the next edge.
